// File: rtl/change_dispenser.sv
// Change payout stage: greedily ejects one coin per clock (10, 5, 2, 1) from a
// per-denomination inventory that is also refilled by front-panel coin deposits.
module change_dispenser #(
   parameter int unsigned WIDTH      = 5,
   parameter int unsigned CNT_W      = 5,
   parameter int unsigned INIT_STOCK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             change_valid,
   input  logic [WIDTH-1:0] change_in,
   input  logic             dep_ten,
   input  logic             dep_five,
   input  logic             dep_two,
   input  logic             dep_one,
   output logic             ready,
   output logic             coin_ten,
   output logic             coin_five,
   output logic             coin_two,
   output logic             coin_one,
   output logic             done,
   output logic             short,
   output logic [WIDTH-1:0] change_left,
   output logic [CNT_W-1:0] stock_ten,
   output logic [CNT_W-1:0] stock_five,
   output logic [CNT_W-1:0] stock_two,
   output logic [CNT_W-1:0] stock_one
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [WIDTH-1:0] DenTen  = WIDTH'(10);
   localparam logic [WIDTH-1:0] DenFive = WIDTH'(5);
   localparam logic [WIDTH-1:0] DenTwo  = WIDTH'(2);
   localparam logic [WIDTH-1:0] DenOne  = WIDTH'(1);
   localparam logic [CNT_W-1:0] StockMax  = '1;
   localparam logic [CNT_W-1:0] StockInit = CNT_W'(INIT_STOCK);

   // Bit 3 = ten, 2 = five, 1 = two, 0 = one throughout.
   state_e                      state_q, state_d;
   logic [WIDTH-1:0]            change_left_q, change_left_d;
   logic [3:0]                  coin_q, coin_d;
   logic                        done_q, done_d;
   logic                        short_q, short_d;
   logic [3:0][CNT_W-1:0]       stock_q, stock_d;
   logic [3:0]                  dep;
   logic [3:0]                  avail;
   logic [3:0]                  pick;
   logic [WIDTH-1:0]            pick_val;

   assign dep = {dep_ten, dep_five, dep_two, dep_one};

   always_comb begin
      avail[3] = (stock_q[3] != '0) && (change_left_q >= DenTen);
      avail[2] = (stock_q[2] != '0) && (change_left_q >= DenFive);
      avail[1] = (stock_q[1] != '0) && (change_left_q >= DenTwo);
      avail[0] = (stock_q[0] != '0) && (change_left_q >= DenOne);
      pick     = 4'b0000;
      pick_val = '0;
      if (avail[3]) begin
         pick     = 4'b1000;
         pick_val = DenTen;
      end else if (avail[2]) begin
         pick     = 4'b0100;
         pick_val = DenFive;
      end else if (avail[1]) begin
         pick     = 4'b0010;
         pick_val = DenTwo;
      end else if (avail[0]) begin
         pick     = 4'b0001;
         pick_val = DenOne;
      end
   end

   always_comb begin
      state_d       = state_q;
      change_left_d = change_left_q;
      short_d       = short_q;
      done_d        = 1'b0;
      coin_d        = 4'b0000;
      unique case (state_q)
         StIdle: begin
            if (change_valid) begin
               change_left_d = change_in;
               short_d       = 1'b0;
               state_d       = StRun;
            end
         end
         StRun: begin
            if (change_left_q == '0) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (pick != 4'b0000) begin
               coin_d        = pick;
               change_left_d = change_left_q - pick_val;
            end else begin
               short_d = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A deposit at saturation is dropped; dispense never underflows since pick needs stock>0.
      for (int i = 0; i < 4; i++) begin
         stock_d[i] = stock_q[i];
         if (dep[i] && !coin_d[i]) begin
            if (stock_q[i] != StockMax) stock_d[i] = stock_q[i] + CNT_W'(1);
         end else if (!dep[i] && coin_d[i]) begin
            stock_d[i] = stock_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         change_left_q <= '0;
         coin_q        <= 4'b0000;
         done_q        <= 1'b0;
         short_q       <= 1'b0;
         stock_q       <= {4{StockInit}};
      end else begin
         state_q       <= state_d;
         change_left_q <= change_left_d;
         coin_q        <= coin_d;
         done_q        <= done_d;
         short_q       <= short_d;
         stock_q       <= stock_d;
      end
   end

   assign ready       = (state_q == StIdle);
   assign coin_ten    = coin_q[3];
   assign coin_five   = coin_q[2];
   assign coin_two    = coin_q[1];
   assign coin_one    = coin_q[0];
   assign done        = done_q;
   assign short       = short_q;
   assign change_left = change_left_q;
   assign stock_ten   = stock_q[3];
   assign stock_five  = stock_q[2];
   assign stock_two   = stock_q[1];
   assign stock_one   = stock_q[0];

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

   logic       clk;
   logic       reset;
   logic       change_valid;
   logic [4:0] change_in;
   logic       dep_ten, dep_five, dep_two, dep_one;
   logic       ready, coin_ten, coin_five, coin_two, coin_one, done, short;
   logic [4:0] change_left, stock_ten, stock_five, stock_two, stock_one;

   int checks = 0;
   int errors = 0;

   change_dispenser #(.WIDTH(5), .CNT_W(5), .INIT_STOCK(4)) dut (
      .clk(clk), .reset(reset), .change_valid(change_valid), .change_in(change_in),
      .dep_ten(dep_ten), .dep_five(dep_five), .dep_two(dep_two), .dep_one(dep_one),
      .ready(ready), .coin_ten(coin_ten), .coin_five(coin_five), .coin_two(coin_two),
      .coin_one(coin_one), .done(done), .short(short), .change_left(change_left),
      .stock_ten(stock_ten), .stock_five(stock_five), .stock_two(stock_two),
      .stock_one(stock_one)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      tick();
   endtask

   // Issues one request and records the coin sequence (one byte per coin, oldest first),
   // the cycle count up to and including done (0 on timeout), and any overlap violation.
   task automatic run_req(input logic [4:0] amt, input bit dep10_first,
                          output logic [31:0] seq, output int ncyc, output bit overlap);
      int cnt;
      bit seen;
      seq = '0; ncyc = 0; overlap = 1'b0; seen = 1'b0;
      change_valid = 1'b1;
      change_in = amt;
      tick();
      change_valid = 1'b0;
      dep_ten = dep10_first;
      for (int c = 1; c <= 40 && !seen; c++) begin
         tick();
         dep_ten = 1'b0;
         cnt = int'(coin_ten) + int'(coin_five) + int'(coin_two) + int'(coin_one);
         if (cnt > 1 || (done && cnt != 0)) overlap = 1'b1;
         if (coin_ten)  seq = (seq << 8) | 32'd10;
         if (coin_five) seq = (seq << 8) | 32'd5;
         if (coin_two)  seq = (seq << 8) | 32'd2;
         if (coin_one)  seq = (seq << 8) | 32'd1;
         if (done) begin
            seen = 1'b1;
            ncyc = c;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({ready, coin_ten, coin_five, coin_two, coin_one, done, short} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 1000000",
                  {ready, coin_ten, coin_five, coin_two, coin_one, done, short});
      end
      checks++;
      if (change_left !== 5'd0) begin
         errors++; $display("FAIL reset_change_left got %0d exp 0", change_left);
      end
      checks++;
      if ({stock_ten, stock_five, stock_two, stock_one} !== {5'd4, 5'd4, 5'd4, 5'd4}) begin
         errors++;
         $display("FAIL reset_stock got %0d/%0d/%0d/%0d exp 4/4/4/4",
                  stock_ten, stock_five, stock_two, stock_one);
      end
   endtask

   task automatic test_pay18();
      logic [31:0] seq; int ncyc; bit ov;
      run_req(5'd18, 1'b0, seq, ncyc, ov);
      checks++;
      if (seq !== 32'h0A050201) begin
         errors++; $display("FAIL pay18_seq got %h exp 0a050201", seq);
      end
      checks++;
      if (ncyc !== 5) begin errors++; $display("FAIL pay18_latency got %0d exp 5", ncyc); end
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL pay18_overlap got %0d exp 0", ov); end
      checks++;
      if ({stock_ten, stock_five, stock_two, stock_one} !== {5'd3, 5'd3, 5'd3, 5'd3}) begin
         errors++;
         $display("FAIL pay18_stock got %0d/%0d/%0d/%0d exp 3/3/3/3",
                  stock_ten, stock_five, stock_two, stock_one);
      end
      checks++;
      if ({ready, short, change_left} !== {1'b1, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL pay18_end got ready=%0d short=%0d left=%0d exp 1 0 0",
                  ready, short, change_left);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL pay18_done_pulse got %0d exp 0", done); end
   endtask

   task automatic test_zero();
      logic [31:0] seq; int ncyc; bit ov;
      run_req(5'd0, 1'b0, seq, ncyc, ov);
      checks++;
      if (ncyc !== 1 || seq !== 32'h0) begin
         errors++; $display("FAIL zero_req got cyc=%0d seq=%h exp 1 0", ncyc, seq);
      end
      checks++;
      if ({stock_ten, stock_five, stock_two, stock_one} !== {5'd3, 5'd3, 5'd3, 5'd3}) begin
         errors++;
         $display("FAIL zero_stock got %0d/%0d/%0d/%0d exp 3/3/3/3",
                  stock_ten, stock_five, stock_two, stock_one);
      end
   endtask

   task automatic test_pay30();
      logic [31:0] seq; int ncyc; bit ov;
      do_reset();
      run_req(5'd30, 1'b0, seq, ncyc, ov);
      checks++;
      if (seq !== 32'h000A0A0A || ncyc !== 4) begin
         errors++; $display("FAIL pay30 got seq=%h cyc=%0d exp 000a0a0a 4", seq, ncyc);
      end
      checks++;
      if (stock_ten !== 5'd1) begin
         errors++; $display("FAIL pay30_stock_ten got %0d exp 1", stock_ten);
      end
   endtask

   task automatic test_short();
      logic [31:0] seq; int ncyc; bit ov;
      for (int k = 0; k < 4; k++) run_req(5'd1, 1'b0, seq, ncyc, ov);
      checks++;
      if (stock_one !== 5'd0) begin
         errors++; $display("FAIL drain_ones got %0d exp 0", stock_one);
      end
      run_req(5'd3, 1'b0, seq, ncyc, ov);
      checks++;
      if (seq !== 32'h02 || ncyc !== 2) begin
         errors++; $display("FAIL short_seq got seq=%h cyc=%0d exp 02 2", seq, ncyc);
      end
      checks++;
      if ({short, change_left, stock_two} !== {1'b1, 5'd1, 5'd3}) begin
         errors++;
         $display("FAIL short_state got short=%0d left=%0d two=%0d exp 1 1 3",
                  short, change_left, stock_two);
      end
      tick(); tick(); tick();
      checks++;
      if (short !== 1'b1) begin errors++; $display("FAIL short_sticky got %0d exp 1", short); end
      change_valid = 1'b1;
      change_in = 5'd0;
      tick();
      change_valid = 1'b0;
      checks++;
      if (short !== 1'b0) begin errors++; $display("FAIL short_clear got %0d exp 0", short); end
      tick();
   endtask

   task automatic test_deposit();
      logic [31:0] seq; int ncyc; bit ov;
      do_reset();
      run_req(5'd20, 1'b1, seq, ncyc, ov);
      checks++;
      if (seq !== 32'h0A0A || stock_ten !== 5'd3) begin
         errors++; $display("FAIL dep_and_disp got seq=%h ten=%0d exp 0a0a 3", seq, stock_ten);
      end
      do_reset();
      dep_ten = 1'b1; dep_five = 1'b1; dep_two = 1'b1; dep_one = 1'b1;
      tick();
      dep_five = 1'b0; dep_two = 1'b0; dep_one = 1'b0;
      checks++;
      if ({stock_five, stock_two, stock_one} !== {5'd5, 5'd5, 5'd5}) begin
         errors++;
         $display("FAIL multi_dep got %0d/%0d/%0d exp 5/5/5", stock_five, stock_two, stock_one);
      end
      for (int k = 1; k < 26; k++) tick();
      checks++;
      if (stock_ten !== 5'd30) begin errors++; $display("FAIL dep_count got %0d exp 30", stock_ten); end
      for (int k = 26; k < 40; k++) tick();
      dep_ten = 1'b0;
      checks++;
      if (stock_ten !== 5'd31) begin errors++; $display("FAIL dep_sat got %0d exp 31", stock_ten); end
   endtask

   task automatic test_mid_reset();
      logic [31:0] seq; int ncyc; bit ov;
      do_reset();
      change_valid = 1'b1;
      change_in = 5'd18;
      tick();
      change_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (coin_five !== 1'b1) begin errors++; $display("FAIL mid_second_coin got %0d exp 1", coin_five); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({ready, coin_ten, coin_five, coin_two, coin_one, done, short, change_left} !==
          {7'b1000000, 5'd0}) begin
         errors++;
         $display("FAIL mid_reset_out got %b left=%0d exp 1000000 0",
                  {ready, coin_ten, coin_five, coin_two, coin_one, done, short}, change_left);
      end
      checks++;
      if ({stock_ten, stock_five, stock_two, stock_one} !== {5'd4, 5'd4, 5'd4, 5'd4}) begin
         errors++;
         $display("FAIL mid_reset_stock got %0d/%0d/%0d/%0d exp 4/4/4/4",
                  stock_ten, stock_five, stock_two, stock_one);
      end
      reset = 1'b0;
      tick();
      run_req(5'd7, 1'b0, seq, ncyc, ov);
      checks++;
      if (seq !== 32'h0502 || ncyc !== 3) begin
         errors++; $display("FAIL after_reset7 got seq=%h cyc=%0d exp 0502 3", seq, ncyc);
      end
   endtask

   initial begin
      reset = 1'b0; change_valid = 1'b0; change_in = '0;
      dep_ten = 1'b0; dep_five = 1'b0; dep_two = 1'b0; dep_one = 1'b0;
      #2;
      test_reset();
      test_pay18();
      test_zero();
      test_pay30();
      test_short();
      test_deposit();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream stage of the coke vendor. Accepts the change amount computed after a vend and pays it out one coin per clock. Payout uses greedy denomination selection (10, 5, 2, 1) against a per-denomination coin inventory. The same inventory is replenished by the coin-insert pulses from the front panel, and the block reports completion or a shortfall back to the vending controller.

Parameters:
WIDTH, 5, width of the change amount and of the remaining-change output (max 31).
CNT_W, 5, width of each denomination stock counter.
INIT_STOCK, 4, value loaded into every stock counter on reset.

Ports:
clk  input  1  system clock (the divided clock the vendor FSM runs on); all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
change_valid  input  1  request strobe; sampled only while ready=1.
change_in  input  WIDTH  change amount to pay, in rupees.
dep_ten  input  1  one-cycle pulse; a 10 coin was inserted.
dep_five  input  1  one-cycle pulse; a 5 coin was inserted.
dep_two  input  1  one-cycle pulse; a 2 coin was inserted.
dep_one  input  1  one-cycle pulse; a 1 coin was inserted.
ready  output  1  high in IDLE.
coin_ten  output  1  one-cycle pulse; eject one 10 coin.
coin_five  output  1  one-cycle pulse; eject one 5 coin.
coin_two  output  1  one-cycle pulse; eject one 2 coin.
coin_one  output  1  one-cycle pulse; eject one 1 coin.
done  output  1  one-cycle pulse at the end of every accepted request.
short  output  1  sticky; exact change could not be paid.
change_left  output  WIDTH  remaining unpaid amount.
stock_ten  output  CNT_W  current inventory of 10 coins.
stock_five  output  CNT_W  current inventory of 5 coins.
stock_two  output  CNT_W  current inventory of 2 coins.
stock_one  output  CNT_W  current inventory of 1 coins.

Behaviour:
- Reset (asynchronous, any time, including mid-payout):
  - state=IDLE, ready=1.
  - coin_*=0, done=0, short=0, change_left=0.
  - Every stock_* = INIT_STOCK.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - On an edge with change_valid=1: change_left<=change_in, short<=0, state<=RUN, ready<=0.
  - change_valid while in RUN is ignored and not queued.
- RUN, each edge, using the registered change_left R and the stock values:
  - R==0: done<=1 for one cycle; state<=IDLE.
  - Otherwise pick the first denomination d in the order 10, 5, 2, 1 with d<=R and stock_d>0. Assert coin_d for the next cycle, change_left<=R-d, and decrement stock_d.
  - No d qualifies: short<=1, done<=1 (one cycle), state<=IDLE, change_left holds R.
- Latency: a request accepted at edge n paying K coins gives coin pulses after edges n+1..n+K and done after edge n+K+1; ready is high from that same edge. change_in=0 gives done after edge n+1 with no coins.
- At most one coin_* is high in any cycle. Coin pulses are never back-to-back with done in the same cycle.
- Selection is strictly greedy and never backtracks. Example: R=6 with stock_five>0 and stock_one=0 faults even though 2+2+2 would work. This behaviour is intended.
- Deposits are accepted in any state; several dep_* may be high in the same cycle.
- Stock update per denomination: stock <= stock + dep - disp.
  - Deposit and dispense of the same denomination in the same cycle leaves the stock unchanged.
  - Increment saturates at 2^CNT_W-1; a deposit at saturation is dropped.
  - A decrement never underflows, because selection requires stock>0.
- The selection decision uses the registered stock, not the same-cycle deposit.
- short stays high until the next accepted request or reset.

Test Plan:
1. Reset, then change_in=18 with change_valid for one cycle -> coin_ten, coin_five, coin_two, coin_one on four consecutive cycles; done on the 5th cycle; stocks 3/3/3/3; change_left=0; short=0.
2. change_in=0 -> done exactly one cycle after acceptance; no coin pulses; stocks unchanged.
3. change_in=30 -> coin_ten on three consecutive cycles, then done; stock_ten=1.
4. Drain ones (4 requests of 1), then change_in=3 -> one coin_two, then short=1 with done; change_left=1; short held until the next request.
5. Hold dep_ten high on the same cycle coin_ten is issued during a 20 payout -> stock_ten ends at 3 (4+1-2). Separately, deposit 40 tens from reset -> stock_ten saturates at 31.
6. Assert reset after the second coin of an 18 payout -> all outputs go low immediately, stocks return to 4, ready=1; a new request for 7 then pays 5 then 2.
